// File: rtl/pipe_ctrl_chain_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_chain_pkg
//  Brief    : Shared pipeline control constants, types and hazard helper.
//  Revision : 1.0
// ============================================================================
package pipe_ctrl_chain_pkg;

   localparam int c_CTRL_W    = 17;
   localparam int c_LOAD_BIT  = 3;
   localparam int c_RF_EN_BIT = 0;
   localparam int c_REG_W     = 5;

   localparam logic [c_CTRL_W-1:0] c_NOP_CTRL = '0;

   typedef logic [c_REG_W-1:0] reg_idx_t;

   // Register 0 is hardwired, so a load targeting it never stalls decode.
   function automatic logic f_load_use(
      input logic     valid,
      input logic     is_load,
      input reg_idx_t dest,
      input reg_idx_t rs,
      input reg_idx_t rt
   );
      return valid & is_load & (dest != '0) & ((dest == rs) | (dest == rt));
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_stage
//  Brief    : One ctrl/dest/valid pipeline register with clear and enable.
//  Revision : 1.0
// ============================================================================
module pipe_ctrl_stage
   import pipe_ctrl_chain_pkg::*;
#(
   parameter int CTRL_W = c_CTRL_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_clear,
   input  logic              i_enable,
   input  logic [CTRL_W-1:0] i_ctrl,
   input  logic [4:0]        i_dest,
   input  logic              i_valid,
   output logic [CTRL_W-1:0] o_ctrl,
   output logic [4:0]        o_dest,
   output logic              o_valid
);

   logic [CTRL_W-1:0] r_ctrl;
   logic [4:0]        r_dest;
   logic              r_valid;

   // Clear outranks enable so a flush lands even while the chain is held.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_ctrl  <= CTRL_W'(c_NOP_CTRL);
         r_dest  <= '0;
         r_valid <= 1'b0;
      end else if (i_enable) begin
         r_ctrl  <= i_ctrl;
         r_dest  <= i_dest;
         r_valid <= i_valid;
      end
   end

   assign o_ctrl  = r_ctrl;
   assign o_dest  = r_dest;
   assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl_chain.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_chain
//  Brief    : Post-decode control-word shift chain with hold, per-stage flush,
//             load-use detection, occupancy and saturating bubble counter.
//  Revision : 1.0
// ============================================================================
module pipe_ctrl_chain
   import pipe_ctrl_chain_pkg::*;
#(
   parameter int CTRL_W   = c_CTRL_W,
   parameter int STAGES   = 3,
   parameter int LOAD_BIT = c_LOAD_BIT,
   parameter int CNT_W    = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [CTRL_W-1:0]        id_ctrl,
   input  logic                     id_valid,
   input  logic [4:0]               id_dest,
   input  logic [4:0]               id_rs,
   input  logic [4:0]               id_rt,
   input  logic                     bubble,
   input  logic                     hold,
   input  logic [STAGES-1:0]        flush,
   output logic [STAGES*CTRL_W-1:0] stage_ctrl,
   output logic [STAGES-1:0]        stage_valid,
   output logic [STAGES*5-1:0]      stage_dest,
   output logic                     load_use_hazard,
   output logic [3:0]               occupancy,
   output logic [CNT_W-1:0]         bubble_cnt
);

   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic              w_accept;
   logic [CTRL_W-1:0] w_in_ctrl  [STAGES];
   logic [4:0]        w_in_dest  [STAGES];
   logic              w_in_valid [STAGES];
   logic [CTRL_W-1:0] w_q_ctrl   [STAGES];
   logic [4:0]        w_q_dest   [STAGES];
   logic              w_q_valid  [STAGES];
   logic [3:0]        w_occ;
   logic [CNT_W-1:0]  r_bubble_cnt;

   assign w_accept = id_valid & ~bubble;

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         if (k == 0) begin : g_head
            assign w_in_ctrl[k]  = w_accept ? id_ctrl : CTRL_W'(c_NOP_CTRL);
            assign w_in_dest[k]  = w_accept ? id_dest : 5'd0;
            assign w_in_valid[k] = w_accept;
         end else begin : g_link
            assign w_in_ctrl[k]  = w_q_ctrl[k-1];
            assign w_in_dest[k]  = w_q_dest[k-1];
            assign w_in_valid[k] = w_q_valid[k-1];
         end

         pipe_ctrl_stage #(
            .CTRL_W (CTRL_W)
         ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .i_clear  (flush[k]),
            .i_enable (~hold),
            .i_ctrl   (w_in_ctrl[k]),
            .i_dest   (w_in_dest[k]),
            .i_valid  (w_in_valid[k]),
            .o_ctrl   (w_q_ctrl[k]),
            .o_dest   (w_q_dest[k]),
            .o_valid  (w_q_valid[k])
         );

         assign stage_ctrl[k*CTRL_W +: CTRL_W] = w_q_ctrl[k];
         assign stage_dest[k*5 +: 5]           = w_q_dest[k];
         assign stage_valid[k]                 = w_q_valid[k];
      end
   endgenerate

   assign load_use_hazard = f_load_use(w_q_valid[0], w_q_ctrl[0][LOAD_BIT],
                                       w_q_dest[0], id_rs, id_rt);

   always_comb begin
      w_occ = 4'd0;
      for (int i = 0; i < STAGES; i++) begin
         w_occ = w_occ + {3'd0, stage_valid[i]};
      end
   end

   assign occupancy = w_occ;

   // Counts only bubbles injected at decode; flush-created holes are not bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bubble_cnt <= '0;
      end else if (!hold && !w_accept && (r_bubble_cnt != c_CNT_MAX)) begin
         r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign bubble_cnt = r_bubble_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl_chain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl_chain
//  Brief    : Directed vector bench for pipe_ctrl_chain.
//  Revision : 1.0
// ============================================================================
module tb_pipe_ctrl_chain;

   localparam logic [16:0] c_C1 = 17'h1A5A5;
   localparam logic [16:0] c_C2 = 17'h00008;
   localparam logic [16:0] c_C3 = 17'h0F0F0;
   localparam logic [16:0] c_C4 = 17'h12345;
   localparam logic [16:0] c_C5 = 17'h00ABC;
   localparam logic [16:0] c_C6 = 17'h1FFFF;
   localparam logic [16:0] c_Z  = 17'h00000;

   typedef struct {
      logic        iv;
      logic [16:0] ictrl;
      logic [4:0]  idest;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        bub;
      logic        hld;
      logic [2:0]  fl;
      logic [2:0]  ev;
      logic [50:0] ectrl;
      logic [14:0] edest;
      logic        ehaz;
      logic [3:0]  eocc;
      logic [15:0] ecnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [16:0] id_ctrl;
   logic        id_valid;
   logic [4:0]  id_dest;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        bubble;
   logic        hold;
   logic [2:0]  flush;

   logic [50:0] stage_ctrl;
   logic [2:0]  stage_valid;
   logic [14:0] stage_dest;
   logic        load_use_hazard;
   logic [3:0]  occupancy;
   logic [15:0] bubble_cnt;

   logic [50:0] s_stage_ctrl;
   logic [2:0]  s_stage_valid;
   logic [14:0] s_stage_dest;
   logic        s_load_use_hazard;
   logic [3:0]  s_occupancy;
   logic [3:0]  s_bubble_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   vec_t vecs [12];

   always #5 clk = ~clk;

   pipe_ctrl_chain dut (
      .clk             (clk),
      .reset           (reset),
      .id_ctrl         (id_ctrl),
      .id_valid        (id_valid),
      .id_dest         (id_dest),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .bubble          (bubble),
      .hold            (hold),
      .flush           (flush),
      .stage_ctrl      (stage_ctrl),
      .stage_valid     (stage_valid),
      .stage_dest      (stage_dest),
      .load_use_hazard (load_use_hazard),
      .occupancy       (occupancy),
      .bubble_cnt      (bubble_cnt)
   );

   pipe_ctrl_chain #(.CNT_W(4)) dut_sat (
      .clk             (clk),
      .reset           (reset),
      .id_ctrl         (id_ctrl),
      .id_valid        (id_valid),
      .id_dest         (id_dest),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .bubble          (bubble),
      .hold            (hold),
      .flush           (flush),
      .stage_ctrl      (s_stage_ctrl),
      .stage_valid     (s_stage_valid),
      .stage_dest      (s_stage_dest),
      .load_use_hazard (s_load_use_hazard),
      .occupancy       (s_occupancy),
      .bubble_cnt      (s_bubble_cnt)
   );

   function automatic vec_t mk(
      input logic iv, input logic [16:0] ictrl, input logic [4:0] idest,
      input logic [4:0] rs, input logic [4:0] rt, input logic bub,
      input logic hld, input logic [2:0] fl, input logic [2:0] ev,
      input logic [50:0] ectrl, input logic [14:0] edest, input logic ehaz,
      input logic [3:0] eocc, input logic [15:0] ecnt
   );
      vec_t v;
      v.iv = iv; v.ictrl = ictrl; v.idest = idest; v.rs = rs; v.rt = rt;
      v.bub = bub; v.hld = hld; v.fl = fl; v.ev = ev; v.ectrl = ectrl;
      v.edest = edest; v.ehaz = ehaz; v.eocc = eocc; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [16:0] ictrl, input logic [4:0] idest,
                        input logic [4:0] rs, input logic [4:0] rt, input logic bub,
                        input logic hld, input logic [2:0] fl);
      id_valid = iv; id_ctrl = ictrl; id_dest = idest; id_rs = rs; id_rt = rt;
      bubble = bub; hold = hld; flush = fl;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, c_Z, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000);
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, c_Z, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000);

      vecs[0]  = mk(1, c_C1,  1, 0, 0, 0, 0, 3'b000, 3'b001, {c_Z, c_Z, c_C1},   {5'd0, 5'd0, 5'd1},  0, 1, 0);
      vecs[1]  = mk(0, c_Z,   0, 0, 0, 0, 0, 3'b000, 3'b010, {c_Z, c_C1, c_Z},   {5'd0, 5'd1, 5'd0},  0, 1, 1);
      vecs[2]  = mk(0, c_Z,   0, 0, 0, 0, 0, 3'b000, 3'b100, {c_C1, c_Z, c_Z},   {5'd1, 5'd0, 5'd0},  0, 1, 2);
      vecs[3]  = mk(1, c_C2,  5, 5, 0, 0, 0, 3'b000, 3'b001, {c_Z, c_Z, c_C2},   {5'd0, 5'd0, 5'd5},  1, 1, 2);
      vecs[4]  = mk(1, c_C3,  7, 6, 6, 0, 0, 3'b000, 3'b011, {c_Z, c_C2, c_C3},  {5'd0, 5'd5, 5'd7},  0, 2, 2);
      vecs[5]  = mk(1, c_C4,  9, 0, 0, 0, 0, 3'b000, 3'b111, {c_C2, c_C3, c_C4}, {5'd5, 5'd7, 5'd9},  0, 3, 2);
      vecs[6]  = mk(1, c_C1,  3, 0, 0, 1, 1, 3'b000, 3'b111, {c_C2, c_C3, c_C4}, {5'd5, 5'd7, 5'd9},  0, 3, 2);
      vecs[7]  = mk(0, c_Z,   0, 0, 0, 0, 1, 3'b000, 3'b111, {c_C2, c_C3, c_C4}, {5'd5, 5'd7, 5'd9},  0, 3, 2);
      vecs[8]  = mk(1, c_C5, 10, 0, 0, 0, 0, 3'b000, 3'b111, {c_C3, c_C4, c_C5}, {5'd7, 5'd9, 5'd10}, 0, 3, 2);
      vecs[9]  = mk(1, c_C6, 31, 0, 0, 0, 0, 3'b010, 3'b101, {c_C4, c_Z, c_C6},  {5'd9, 5'd0, 5'd31}, 0, 2, 2);
      vecs[10] = mk(1, c_C1,  1, 0, 0, 0, 1, 3'b001, 3'b100, {c_C4, c_Z, c_Z},   {5'd9, 5'd0, 5'd0},  0, 1, 2);
      vecs[11] = mk(1, c_C1,  1, 0, 0, 1, 0, 3'b000, 3'b000, {c_Z, c_Z, c_Z},    {5'd0, 5'd0, 5'd0},  0, 0, 3);

      // Reset state
      step();
      step();
      chk("rst_valid", 64'(stage_valid), 64'd0);
      chk("rst_ctrl",  64'(stage_ctrl),  64'd0);
      chk("rst_dest",  64'(stage_dest),  64'd0);
      chk("rst_haz",   64'(load_use_hazard), 64'd0);
      chk("rst_occ",   64'(occupancy),   64'd0);
      chk("rst_cnt",   64'(bubble_cnt),  64'd0);
      reset = 1'b0;

      // Table: single word propagation, stream, hold, flush, bubble
      for (int i = 0; i < 12; i++) begin
         drive(vecs[i].iv, vecs[i].ictrl, vecs[i].idest, vecs[i].rs, vecs[i].rt,
               vecs[i].bub, vecs[i].hld, vecs[i].fl);
         step();
         chk($sformatf("v%0d_valid", i), 64'(stage_valid),     64'(vecs[i].ev));
         chk($sformatf("v%0d_ctrl", i),  64'(stage_ctrl),      64'(vecs[i].ectrl));
         chk($sformatf("v%0d_dest", i),  64'(stage_dest),      64'(vecs[i].edest));
         chk($sformatf("v%0d_haz", i),   64'(load_use_hazard), 64'(vecs[i].ehaz));
         chk($sformatf("v%0d_occ", i),   64'(occupancy),       64'(vecs[i].eocc));
         chk($sformatf("v%0d_cnt", i),   64'(bubble_cnt),      64'(vecs[i].ecnt));
      end

      // Load-use hazard variations against a held load in stage 0
      do_reset();
      drive(1'b1, c_C2, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 3'b000);
      step();
      chk("haz_rs_match", 64'(load_use_hazard), 64'd1);
      drive(1'b0, c_Z, 5'd0, 5'd6, 5'd6, 1'b0, 1'b1, 3'b000);
      #1;
      chk("haz_no_match", 64'(load_use_hazard), 64'd0);
      id_rt = 5'd5;
      #1;
      chk("haz_rt_match", 64'(load_use_hazard), 64'd1);
      do_reset();
      drive(1'b1, c_C2, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000);
      step();
      chk("haz_dest0_valid", 64'(stage_valid), 64'd1);
      chk("haz_dest0", 64'(load_use_hazard), 64'd0);

      // Saturation: 20 bubbles
      do_reset();
      drive(1'b1, c_C1, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 3'b000);
      for (int i = 0; i < 20; i++) step();
      chk("sat_cnt4",  64'(s_bubble_cnt), 64'd15);
      chk("cnt16_20",  64'(bubble_cnt),   64'd20);

      // Reset while held with a full chain
      drive(1'b1, c_C3, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 3'b000);
      step();
      step();
      drive(1'b1, c_C2, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 3'b000);
      step();
      chk("full_occ", 64'(occupancy), 64'd3);
      drive(1'b1, c_C1, 5'd9, 5'd5, 5'd0, 1'b1, 1'b1, 3'b111);
      reset = 1'b1;
      step();
      chk("rh_valid", 64'(stage_valid),     64'd0);
      chk("rh_ctrl",  64'(stage_ctrl),      64'd0);
      chk("rh_dest",  64'(stage_dest),      64'd0);
      chk("rh_haz",   64'(load_use_hazard), 64'd0);
      chk("rh_occ",   64'(occupancy),       64'd0);
      chk("rh_cnt",   64'(bubble_cnt),      64'd0);
      chk("rh_cnt4",  64'(s_bubble_cnt),    64'd0);
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl_chain.md
PIPE_CTRL_CHAIN -- requirements
Module: pipe_ctrl_chain

Interface
REQ-001 SHALL have parameter CTRL_W, default 17, width of one control-signal word.
REQ-002 SHALL have parameter STAGES, default 3, number of post-decode stages (EX, MEM, WB); legal range 1..8.
REQ-003 SHALL have parameter LOAD_BIT, default 3, index of the load-instruction bit within a control word.
REQ-004 SHALL have parameter CNT_W, default 16, width of the bubble counter.
REQ-005 SHALL have one clock `clk`; `reset` is synchronous and active-high.
REQ-006 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- id_ctrl  in  CTRL_W  control word from decode
- id_valid  in  1  id_ctrl/id_dest carry a real instruction
- id_dest  in  5  destination register of decoded instruction
- id_rs, id_rt  in  5 each  source registers of the instruction currently in decode
- bubble  in  1  force a NOP into stage 0 (successor to the S mux select)
- hold  in  1  freeze the whole chain
- flush  in  STAGES  per-stage clear request
- stage_ctrl  out  STAGES*CTRL_W  flattened control words; stage k at bits [k*CTRL_W +: CTRL_W]
- stage_valid  out  STAGES  per-stage valid
- stage_dest  out  STAGES*5  flattened destination registers
- load_use_hazard  out  1  load in stage 0 feeds the instruction in decode
- occupancy  out  4  count of set stage_valid bits
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted

Function
REQ-007 SHALL update all stage registers only on rising clk.
REQ-008 SHALL, when hold=0, load stage 0 with {id_ctrl, id_dest, valid=1} if id_valid=1 and bubble=0; otherwise with all-zero ctrl, dest 0, valid 0.
REQ-009 SHALL, when hold=0, load stage k (k>=1) with stage k-1's ctrl, dest and valid.
REQ-010 SHALL, when hold=1, keep every stage unchanged; id inputs and bubble are ignored.
REQ-011 SHALL treat flush[k]=1 in cycle t as: stage k holds zero ctrl, dest 0, valid 0 after the edge; this overrides both hold and shift for stage k only.
REQ-012 SHALL resolve priority per stage as reset > flush[k] > hold > bubble/!id_valid > normal load.
REQ-013 SHALL have one-cycle latency per stage: an id_ctrl accepted at edge n appears in stage k after edge n+k (hold=0 throughout).
REQ-014 SHALL drive load_use_hazard combinationally = stage_valid[0] & stage0 ctrl[LOAD_BIT] & (stage0 dest != 0) & (stage0 dest == id_rs | stage0 dest == id_rt).
REQ-015 SHALL drive occupancy combinationally as the popcount of stage_valid.
REQ-016 SHALL increment bubble_cnt by 1 on each edge where hold=0 and stage 0 is loaded invalid (bubble=1 or id_valid=0), saturating at 2^CNT_W-1 without wrapping.
REQ-017 SHALL not count bubbles produced by flush, and shall not count during hold.

Reset
REQ-018 SHALL, on reset=1 at a clk edge, clear all stage_ctrl, stage_dest and stage_valid to 0 and bubble_cnt to 0, overriding hold, flush and bubble.
REQ-019 SHALL output load_use_hazard=0 and occupancy=0 in the cycle after reset.
REQ-020 SHALL treat reset asserted mid-stream identically to power-up reset; no in-flight word survives.

Structure
REQ-021 SHALL keep the default CTRL_W, the LOAD_BIT/RF-enable bit positions and the NOP control constant in the shared pipeline package used by the control unit.
REQ-022 SHALL implement each stage as one instance of a sub-module pipe_ctrl_stage (ctrl/dest/valid register with clear and enable), generated STAGES times.

Verification
REQ-023 SHALL cover: after reset, id_valid=1, id_ctrl=17'h1A5A5 for 1 cycle -> stage_ctrl[0]=1A5A5 after edge 1, stage 2 after edge 3, occupancy 1 throughout.
REQ-024 SHALL cover: stream 3 valid words, hold=1 for 2 cycles -> all stages unchanged, bubble_cnt unchanged, then resumes shifting.
REQ-025 SHALL cover: flush=3'b010 with stages full -> stage 1 valid=0 next cycle, stages 0 and 2 shift normally, bubble_cnt unchanged.
REQ-026 SHALL cover: stage 0 holds load (ctrl[3]=1) dest=5, id_rs=5 -> load_use_hazard=1; dest=0 or id_rs=id_rt=6 -> 0.
REQ-027 SHALL cover: CNT_W=4, bubble=1 for 20 cycles -> bubble_cnt saturates at 15.
REQ-028 SHALL cover: reset asserted with hold=1 and full chain -> all outputs zero after one edge.
